// File: rtl/apb_pkg.sv
// Shared APB definitions: state encoding, bus widths and the fixed read value
// returned when a read is not serviced.
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  localparam logic [APB_DW-1:0] APB_ERR_RDATA = 32'h0;

  // One-hot-ish two-bit encoding shared with the bridge master.
  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    SETUP  = 2'b10,
    ACCESS = 2'b11
  } apb_state_e;

  // The protocol phase is fully determined by the select/enable pair.
  function automatic apb_state_e apb_phase(input logic psel, input logic penable);
    apb_state_e ph;
    if (!psel) begin
      ph = IDLE;
    end else if (!penable) begin
      ph = SETUP;
    end else begin
      ph = ACCESS;
    end
    return ph;
  endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// Wait-state counter and Pready generation for one APB completer.
module apb_wait_gen
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic Pclk,
  input  logic Presetn,
  input  logic access,
  output logic Pready
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [3:0] wcnt;

  // Pready is low for WAIT_STATES access cycles, then high for one.
  assign Pready = !access || (wcnt == WS);

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      wcnt <= 4'd0;
    end else if (access && !Pready) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory, with programmable
// wait states, address-error responses and transfer statistics.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        Pclk,
  input  logic        Presetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [7:0]  err_count,
  output logic [1:0]  state_dbg
);

  localparam int          IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [31:0] SPAN     = 32'(MEM_DEPTH) * 32'd4;

  // Handshake: a transfer completes on the rising edge where Psel, Penable
  // and Pready are all high; Paddr/Pwrite/Pwdata are sampled live then.
  logic             access;
  logic             complete;
  logic [APB_AW-1:0] offset;
  logic             err;
  logic [IDX_W-1:0] idx;
  apb_state_e       state;

  logic [APB_DW-1:0] mem [MEM_DEPTH];

  assign access   = Psel && Penable;
  assign complete = access && Pready;

  // Address decode; addresses below the base are errors rather than aliases.
  assign offset = Paddr - BASE_ADDR;
  assign err    = (Paddr[1:0] != 2'b00) || (Paddr < BASE_ADDR) || (offset >= SPAN);
  assign idx    = offset[IDX_W+1:2];

  apb_wait_gen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_gen (
    .Pclk    (Pclk),
    .Presetn (Presetn),
    .access  (access),
    .Pready  (Pready)
  );

  assign Pslverr = complete && err;
  assign Prdata  = (access && !Pwrite && !err) ? mem[idx] : APB_ERR_RDATA;

  assign state_dbg = state;

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state <= IDLE;
    end else begin
      state <= apb_phase(Psel, Penable);
    end
  end

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && Pwrite && !err) begin
      mem[idx] <= Pwdata;
    end
  end

  // wr/rd counters wrap naturally; the error counter sticks at its maximum.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      wr_count  <= 16'd0;
      rd_count  <= 16'd0;
      err_count <= 8'd0;
    end else if (complete) begin
      if (err) begin
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else if (Pwrite) begin
        wr_count <= wr_count + 16'd1;
      end else begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule
